dft_butterfly_feeder: RTL and testbench

DFT_BUTTERFLY_FEEDER -- requirements
Module: dft_butterfly_feeder

---
 rtl/dft_butterfly_feeder_if.sv | 27 ++
 rtl/dft_butterfly_feeder.sv | 86 ++++++++
 tb/tb_dft_butterfly_feeder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/dft_butterfly_feeder_if.sv
// dft_butterfly_feeder_if: stream, adder-subtractor and output-pair signals of the butterfly feeder
// Signals: in_valid/in_ready/in_a/in_b (input pairs), addsub/data_a/data_b/result (adder-subtractor),
//          out_valid/out_ready/out_sum/out_diff (output pairs). slave = feeder side, master = environment side.
interface dft_butterfly_feeder_if #(
  parameter int DATA_W = 32
) ();
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic addsub;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic [DATA_W-1:0] result;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out_sum;
  logic [DATA_W-1:0] out_diff;
  modport slave (
    input in_valid, in_a, in_b, result, out_ready,
    output in_ready, addsub, data_a, data_b, out_valid, out_sum, out_diff
  );
  modport master (
    output in_valid, in_a, in_b, result, out_ready,
    input in_ready, addsub, data_a, data_b, out_valid, out_sum, out_diff
  );
endinterface

// File: rtl/dft_butterfly_feeder.sv
// dft_butterfly_feeder: issues each (a,b) pair as an add then a subtract to an external adder-subtractor
// and queues the {sum, diff} results in a credit-controlled output FIFO.
// Ports: clk, rst (asynchronous, active-low), bus (dft_butterfly_feeder_if.slave),
//        pair_cnt [15:0] (count of popped pairs, only with DFT_FEEDER_STATS_EN defined).
module dft_butterfly_feeder #(
  parameter int DATA_W = 32,
  parameter int ADDSUB_LAT = 1,
  parameter int OUT_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  dft_butterfly_feeder_if.slave bus
`ifdef DFT_FEEDER_STATS_EN
  ,
  output logic [15:0] pair_cnt
`endif
);
  localparam int AW = $clog2(OUT_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(OUT_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE_ADD, ISSUE_SUB} state_t;
  state_t state, state_nx;
  logic [AW:0] occ, fcnt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [2*DATA_W-1:0] mem [OUT_DEPTH];
  logic [ADDSUB_LAT-1:0] tag_v, tag_add;
  logic [DATA_W-1:0] sum_q;
  logic acc, pop, push, issue;
  // occ reserves a FIFO slot at accept time, so a pair in flight always has room to land
  assign bus.in_ready = rst && (state == IDLE || state == ISSUE_SUB) && occ < DEPTH;
  assign acc = bus.in_valid && bus.in_ready;
  assign bus.out_valid = fcnt != '0;
  assign pop = bus.out_valid && bus.out_ready;
  assign issue = state != IDLE;
  // the tag at the end of the pipe lines up with the result of the operation issued ADDSUB_LAT cycles ago
  assign push = tag_v[ADDSUB_LAT-1] && !tag_add[ADDSUB_LAT-1];
  assign {bus.out_sum, bus.out_diff} = bus.out_valid ? mem[rd_ptr] : '0;
  always_comb begin
    state_nx = state == ISSUE_ADD ? ISSUE_SUB : acc ? ISSUE_ADD : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ <= '0;
      bus.addsub <= 1'b1;
      bus.data_a <= '0;
      bus.data_b <= '0;
      tag_v <= '0;
      tag_add <= '0;
      sum_q <= '0;
    end else begin
      occ <= occ + (AW+1)'(acc) - (AW+1)'(pop);
      bus.addsub <= state_nx != ISSUE_SUB;
      if (acc) begin
        bus.data_a <= bus.in_a;
        bus.data_b <= bus.in_b;
      end
      tag_v <= ADDSUB_LAT'({tag_v, issue});
      tag_add <= ADDSUB_LAT'({tag_add, state == ISSUE_ADD});
      if (tag_v[ADDSUB_LAT-1] && tag_add[ADDSUB_LAT-1]) sum_q <= bus.result;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fcnt <= fcnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {sum_q, bus.result};
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && fcnt == DEPTH && !pop));
`ifdef DFT_FEEDER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pair_cnt <= '0;
    else if (pop) pair_cnt <= pair_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_dft_butterfly_feeder.sv
// tb_dft_butterfly_feeder: scoreboard bench for dft_butterfly_feeder with a one-cycle adder-subtractor model
module tb_dft_butterfly_feeder;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  dft_butterfly_feeder_if #(.DATA_W(W)) bus ();
`ifdef DFT_FEEDER_STATS_EN
  logic [15:0] pair_cnt;
`endif
  dft_butterfly_feeder #(.DATA_W(W), .ADDSUB_LAT(1), .OUT_DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef DFT_FEEDER_STATS_EN
    ,
    .pair_cnt(pair_cnt)
`endif
  );
  always @(posedge clk) bus.result <= bus.addsub ? bus.data_a + bus.data_b : bus.data_a - bus.data_b;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int gap = 0;
  int pops = 0;
  int pops_base = 0;
  logic [63:0] sb[$];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back({bus.in_a + bus.in_b, bus.in_a - bus.in_b});
        gap = cyc - acc_cyc;
        acc_cyc = cyc;
      end
      if (bus.out_valid && bus.out_ready) begin
        pops++;
        chk("pending", 64'(sb.size() != 0), 1);
        if (sb.size() != 0) chk("pair", {bus.out_sum, bus.out_diff}, sb.pop_front());
      end
    end
  end
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    chk("accept", 64'(ok), 1);
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", 64'(sb.size()), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end
  initial begin
    int seen;
    int p0;
    bit rdone;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_addsub", bus.addsub, 1);
    chk("rst_data_a", bus.data_a, 0);
    chk("rst_data_b", bus.data_b, 0);
    chk("rst_out_sum", bus.out_sum, 0);
    chk("rst_out_diff", bus.out_diff, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_release", bus.in_ready, 1);
    @(posedge clk);
    #1;
    send(7, 3);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t1_addsub", bus.addsub, 1);
    chk("t1_data_a", bus.data_a, 7);
    chk("t1_data_b", bus.data_b, 3);
    chk("t1_out_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("t2_addsub", bus.addsub, 0);
    chk("t2_data_a", bus.data_a, 7);
    @(negedge clk);
    chk("t3_out_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("t4_out_valid", bus.out_valid, 1);
    chk("t4_latency", 64'(cyc - acc_cyc), 4);
    chk("t4_out_sum", bus.out_sum, 10);
    chk("t4_out_diff", bus.out_diff, 4);
    @(negedge clk);
    chk("t5_out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
    send(1, 1);
    send(5, 2);
    chk("b2b_gap1", 64'(gap), 2);
    send(9, 4);
    chk("b2b_gap2", 64'(gap), 2);
    bus.in_valid = 1'b0;
    drain();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'(100 + i), 32'(i));
    bus.in_valid = 1'b1;
    bus.in_a = 200;
    bus.in_b = 50;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.in_ready) seen++;
    end
    chk("full_blocks", 64'(seen), 0);
    chk("full_queued", 64'(sb.size()), 4);
    chk("full_out_valid", bus.out_valid, 1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(200, 50);
    send(300, 301);
    bus.in_valid = 1'b0;
    drain();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'(1000 * i + 17), 32'(3 * i + 40));
    repeat (6) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(32'hFFFF_FFFF, 2);
    send(0, 1);
    bus.in_valid = 1'b0;
    drain();
    rdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          send($urandom, $urandom);
          if ($urandom_range(0, 2) == 0) begin
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
        end
        bus.in_valid = 1'b0;
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();
    send(11, 2);
    send(20, 5);
    bus.in_valid = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_addsub", bus.addsub, 1);
    chk("midrst_data_a", bus.data_a, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    pops_base = pops;
    p0 = pops;
    @(negedge clk);
    chk("midrst_ready_after", bus.in_ready, 1);
    repeat (10) @(negedge clk);
    chk("no_stale", 64'(pops - p0), 0);
    chk("no_stale_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
    send(3, 3);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
    chk("post_rst_sum", bus.out_sum, 6);
    chk("post_rst_diff", bus.out_diff, 0);
    drain();
    chk("post_rst_pops", 64'(pops - p0), 1);
`ifdef DFT_FEEDER_STATS_EN
    chk("pair_cnt", pair_cnt, 16'(pops - pops_base));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
